// File: rtl/maxnet_ctrl_seq_if.sv
// Handshake and strobe bundle between the Maxnet sequencer, the top-level
// start/finish logic and the Maxnet datapath.
interface maxnet_ctrl_seq_if #(
  parameter int GRP_W  = 2,
  parameter int ITER_W = 6
);
  logic              start;
  logic              abort;
  logic              valid;
  logic              plu_done;
  logic              start_plu;
  logic [GRP_W-1:0]  grp_idx;
  logic              we_grp;
  logic              we_a_reg;
  logic              we_prim;
  logic              eps_reg_we;
  logic              mux_sel;
  logic              dp_clr;
  logic [ITER_W-1:0] iter_cnt;
  logic              busy;
  logic              finish;
  logic [1:0]        status;

  modport master (
    input  start, abort, valid, plu_done,
    output start_plu, grp_idx, we_grp, we_a_reg, we_prim, eps_reg_we,
           mux_sel, dp_clr, iter_cnt, busy, finish, status
  );

  modport slave (
    output start, abort, valid, plu_done,
    input  start_plu, grp_idx, we_grp, we_a_reg, we_prim, eps_reg_we,
           mux_sel, dp_clr, iter_cnt, busy, finish, status
  );
endinterface

// File: rtl/maxnet_ctrl_seq.sv
// Maxnet sequencer: runs N_NEURON neurons through LANES parallel PLUs group by
// group, iterates until convergence, iteration cap, PLU timeout or abort.
module maxnet_ctrl_seq #(
  parameter int N_NEURON = 8,
  parameter int LANES    = 2,
  parameter int MAX_ITER = 32,
  parameter int PLU_TMO  = 255,
  parameter int GRP_W    = ((N_NEURON / LANES) > 1) ? $clog2(N_NEURON / LANES) : 1,
  parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  maxnet_ctrl_seq_if.master    bus
);

  localparam int GROUPS = N_NEURON / LANES;
  localparam int WD_W   = (PLU_TMO > 1) ? $clog2(PLU_TMO) : 1;

  localparam logic [GRP_W-1:0]  LAST_GRP = GRP_W'(GROUPS - 1);
  localparam logic [ITER_W-1:0] ITER_CAP = ITER_W'(MAX_ITER);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(PLU_TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ISSUE,
    S_WAIT,
    S_STORE,
    S_COMMIT,
    S_CHECK,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_CONVERGED = 2'b00,
    ST_MAX_ITER  = 2'b01,
    ST_TIMEOUT   = 2'b10,
    ST_ABORTED   = 2'b11
  } status_t;

  typedef struct packed {
    logic start_plu;
    logic we_grp;
    logic we_a_reg;
    logic we_prim;
    logic eps_reg_we;
    logic mux_sel;
    logic dp_clr;
    logic finish;
  } strobe_t;

  state_t            state, state_nxt;
  status_t           status, status_nxt;
  logic [GRP_W-1:0]  grp_idx, grp_nxt;
  logic [ITER_W-1:0] iter_cnt, iter_nxt;
  logic [WD_W-1:0]   wd_cnt, wd_nxt;
  strobe_t           stb;
  logic              abortable;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      status   <= ST_CONVERGED;
      grp_idx  <= '0;
      iter_cnt <= '0;
      wd_cnt   <= '0;
    end else begin
      // NOTE: non-blocking so every register here updates from pre-edge values.
      state    <= state_nxt;
      status   <= status_nxt;
      grp_idx  <= grp_nxt;
      iter_cnt <= iter_nxt;
      wd_cnt   <= wd_nxt;
    end
  end

  assign abortable = (state == S_ISSUE) || (state == S_WAIT) || (state == S_STORE) ||
                     (state == S_COMMIT) || (state == S_CHECK);

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_nxt  = state;
    status_nxt = status;
    grp_nxt    = grp_idx;
    iter_nxt   = iter_cnt;
    wd_nxt     = wd_cnt;

    case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = S_INIT;
      end
      S_INIT: begin
        grp_nxt    = '0;
        iter_nxt   = '0;
        status_nxt = ST_CONVERGED;
        wd_nxt     = '0;
        state_nxt  = S_ISSUE;
      end
      S_ISSUE: begin
        wd_nxt    = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.plu_done) begin
          state_nxt = S_STORE;
        end else if (PLU_TMO != 0) begin
          // The watchdog holds PLU_TMO-1 on the last permitted WAIT cycle.
          if (wd_cnt == WD_LAST) begin
            state_nxt  = S_DONE;
            status_nxt = ST_TIMEOUT;
          end else begin
            wd_nxt = wd_cnt + WD_W'(1);
          end
        end
      end
      S_STORE: begin
        if (grp_idx == LAST_GRP) begin
          grp_nxt   = '0;
          state_nxt = S_COMMIT;
        end else begin
          grp_nxt   = grp_idx + GRP_W'(1);
          state_nxt = S_ISSUE;
        end
      end
      S_COMMIT: begin
        iter_nxt  = iter_cnt + ITER_W'(1);
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (bus.valid) begin
          state_nxt  = S_DONE;
          status_nxt = ST_CONVERGED;
        end else if (iter_cnt == ITER_CAP) begin
          state_nxt  = S_DONE;
          status_nxt = ST_MAX_ITER;
        end else begin
          state_nxt = S_ISSUE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides both the timeout and the normal successor; counter
    // updates of the current state still take effect with its strobes.
    if (bus.abort && abortable) begin
      state_nxt  = S_DONE;
      status_nxt = ST_ABORTED;
    end
  end

  always_comb begin
    stb = '0;
    case (state)
      S_INIT: begin
        stb.we_a_reg   = 1'b1;
        stb.we_prim    = 1'b1;
        stb.eps_reg_we = 1'b1;
        stb.mux_sel    = 1'b1;
        stb.dp_clr     = 1'b1;
      end
      S_ISSUE:  stb.start_plu = 1'b1;
      S_STORE:  stb.we_grp    = 1'b1;
      S_COMMIT: stb.we_a_reg  = 1'b1;
      S_DONE:   stb.finish    = 1'b1;
      default:  stb = '0;
    endcase
  end

  assign bus.start_plu  = stb.start_plu;
  assign bus.we_grp     = stb.we_grp;
  assign bus.we_a_reg   = stb.we_a_reg;
  assign bus.we_prim    = stb.we_prim;
  assign bus.eps_reg_we = stb.eps_reg_we;
  assign bus.mux_sel    = stb.mux_sel;
  assign bus.dp_clr     = stb.dp_clr;
  assign bus.finish     = stb.finish;
  assign bus.busy       = (state != S_IDLE);
  assign bus.grp_idx    = grp_idx;
  assign bus.iter_cnt   = iter_cnt;
  assign bus.status     = status;

  a_finish_single: assert property (@(posedge clk) disable iff (rst) bus.finish |=> !bus.finish);
  a_iter_capped:   assert property (@(posedge clk) disable iff (rst) iter_cnt <= ITER_CAP);

endmodule

// File: tb/tb_maxnet_ctrl_seq.sv
// Directed bench for maxnet_ctrl_seq: four parameterisations share one set of
// stimulus signals, routed to the instance selected by sel.
module tb_maxnet_ctrl_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, valid = 1'b0, plu_done = 1'b0;
  int   sel = 0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct packed {
    logic start_plu, we_grp, we_a_reg, we_prim, eps_reg_we, mux_sel, dp_clr, busy, finish;
    logic [1:0] status;
    logic [7:0] grp;
    logic [7:0] iter;
  } obs_t;

  maxnet_ctrl_seq_if #(.GRP_W(2), .ITER_W(6)) if0 ();
  maxnet_ctrl_seq_if #(.GRP_W(1), .ITER_W(2)) if1 ();
  maxnet_ctrl_seq_if #(.GRP_W(2), .ITER_W(6)) if2 ();
  maxnet_ctrl_seq_if #(.GRP_W(1), .ITER_W(6)) if3 ();

  maxnet_ctrl_seq u0 (.clk(clk), .rst(rst), .bus(if0.master));
  maxnet_ctrl_seq #(.N_NEURON(4), .LANES(2), .MAX_ITER(3)) u1 (.clk(clk), .rst(rst), .bus(if1.master));
  maxnet_ctrl_seq #(.PLU_TMO(4)) u2 (.clk(clk), .rst(rst), .bus(if2.master));
  maxnet_ctrl_seq #(.N_NEURON(4), .LANES(4)) u3 (.clk(clk), .rst(rst), .bus(if3.master));

  assign if0.start = start & (sel == 0);  assign if0.abort = abort & (sel == 0);
  assign if0.valid = valid & (sel == 0);  assign if0.plu_done = plu_done & (sel == 0);
  assign if1.start = start & (sel == 1);  assign if1.abort = abort & (sel == 1);
  assign if1.valid = valid & (sel == 1);  assign if1.plu_done = plu_done & (sel == 1);
  assign if2.start = start & (sel == 2);  assign if2.abort = abort & (sel == 2);
  assign if2.valid = valid & (sel == 2);  assign if2.plu_done = plu_done & (sel == 2);
  assign if3.start = start & (sel == 3);  assign if3.abort = abort & (sel == 3);
  assign if3.valid = valid & (sel == 3);  assign if3.plu_done = plu_done & (sel == 3);

  obs_t o0, o1, o2, o3, o;
  assign o0 = {if0.start_plu, if0.we_grp, if0.we_a_reg, if0.we_prim, if0.eps_reg_we, if0.mux_sel,
               if0.dp_clr, if0.busy, if0.finish, if0.status, 8'(if0.grp_idx), 8'(if0.iter_cnt)};
  assign o1 = {if1.start_plu, if1.we_grp, if1.we_a_reg, if1.we_prim, if1.eps_reg_we, if1.mux_sel,
               if1.dp_clr, if1.busy, if1.finish, if1.status, 8'(if1.grp_idx), 8'(if1.iter_cnt)};
  assign o2 = {if2.start_plu, if2.we_grp, if2.we_a_reg, if2.we_prim, if2.eps_reg_we, if2.mux_sel,
               if2.dp_clr, if2.busy, if2.finish, if2.status, 8'(if2.grp_idx), 8'(if2.iter_cnt)};
  assign o3 = {if3.start_plu, if3.we_grp, if3.we_a_reg, if3.we_prim, if3.eps_reg_we, if3.mux_sel,
               if3.dp_clr, if3.busy, if3.finish, if3.status, 8'(if3.grp_idx), 8'(if3.iter_cnt)};

  always_comb begin
    case (sel)
      0:       o = o0;
      1:       o = o1;
      2:       o = o2;
      3:       o = o3;
      default: o = '0;
    endcase
  end

  // Results recorded by run(); cycle numbers count negedges after the one where start rises.
  int         r_cycles, r_iter, r_n_plu, r_n_grp, r_n_commit, r_n_init, r_abort_cyc, r_plu_after_abort;
  int         r_c2_iter;
  logic [1:0] r_status, r_c2_status;
  logic [5:0] r_c1;
  logic       r_after_busy, r_after_finish;
  bit         r_expired;
  int         q_grp[$];

  // Drives one run on instance k with a PLU model that answers after w WAIT cycles
  // (w<0: never); valid rises once iter_cnt reaches valid_after (0: never).
  task automatic run(input int k, input int w, input int valid_after,
                     input int abort_grp, input int abort_iter, input bit hold_start);
    int cyc, wcnt;
    bit done, aborted;
    sel = k;
    r_cycles = -1; r_iter = -1; r_n_plu = 0; r_n_grp = 0; r_n_commit = 0; r_n_init = 0;
    r_abort_cyc = -1; r_plu_after_abort = 0; r_status = 'x; r_c1 = 'x; r_c2_status = 'x; r_c2_iter = -1;
    q_grp.delete();
    abort = 0; plu_done = 0; valid = 0; start = 1;
    wcnt = -1; cyc = 0; done = 0; aborted = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!hold_start) start = 0;
      if (cyc == 1) r_c1 = {o.we_a_reg, o.we_prim, o.eps_reg_we, o.mux_sel, o.dp_clr, o.busy};
      if (cyc == 2) begin r_c2_status = o.status; r_c2_iter = int'(o.iter); end
      if (o.start_plu) begin
        r_n_plu++;
        q_grp.push_back(int'(o.grp));
        if (aborted) r_plu_after_abort++;
      end
      if (o.we_grp) r_n_grp++;
      if (o.we_a_reg && !o.mux_sel) r_n_commit++;
      if (o.we_prim) r_n_init++;
      abort = 0;
      plu_done = 0;
      if (o.start_plu) begin
        wcnt = 0;
      end else if (wcnt >= 0) begin
        wcnt++;
        if (wcnt == 1 && int'(o.grp) == abort_grp && int'(o.iter) == abort_iter) begin
          abort = 1; aborted = 1; r_abort_cyc = cyc;
        end
        if (wcnt == w) begin plu_done = 1; wcnt = -1; end
      end
      valid = (valid_after > 0) && (int'(o.iter) >= valid_after);
      if (o.finish) begin
        done = 1; r_cycles = cyc; r_status = o.status; r_iter = int'(o.iter); start = 0;
      end
    end
    r_expired = !done;
    @(negedge clk);
    r_after_busy = o.busy; r_after_finish = o.finish;
    if (o.start_plu && aborted) r_plu_after_abort++;
    valid = 0; abort = 0; plu_done = 0; start = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      sel = k;
      #1;
      n_vec++;
      if (o !== '0) begin n_err++; $display("FAIL reset_outputs[%0d]: got %h want 0", k, o); end
    end
    sel = 0;
  endtask

  task automatic test_basic();
    bit ok;
    run(0, 1, 1, -1, -1, 0);
    n_vec++; if (r_expired) begin n_err++; $display("FAIL basic_finish_seen: got none want 1"); end
    n_vec++; if (r_cycles != 16) begin n_err++; $display("FAIL basic_latency: got %0d want 16", r_cycles); end
    n_vec++; if (r_n_plu != 4) begin n_err++; $display("FAIL basic_start_plu: got %0d want 4", r_n_plu); end
    n_vec++; if (r_n_grp != 4) begin n_err++; $display("FAIL basic_we_grp: got %0d want 4", r_n_grp); end
    ok = (q_grp.size() == 4);
    for (int i = 0; i < q_grp.size(); i++) if (q_grp[i] != i) ok = 0;
    n_vec++; if (!ok) begin n_err++; $display("FAIL basic_grp_seq: got %p want 0,1,2,3", q_grp); end
    n_vec++; if (r_iter != 1) begin n_err++; $display("FAIL basic_iter: got %0d want 1", r_iter); end
    n_vec++; if (r_status !== 2'b00) begin n_err++; $display("FAIL basic_status: got %b want 00", r_status); end
    n_vec++; if (r_n_commit != 1) begin n_err++; $display("FAIL basic_commit: got %0d want 1", r_n_commit); end
    n_vec++; if (r_c1 !== 6'b111111) begin n_err++; $display("FAIL basic_init_strobes: got %b want 111111", r_c1); end
    n_vec++;
    if (r_after_busy !== 1'b0 || r_after_finish !== 1'b0) begin
      n_err++; $display("FAIL basic_back_to_idle: got busy=%b finish=%b want 0/0", r_after_busy, r_after_finish);
    end
  endtask

  task automatic test_max_iter();
    run(1, 1, 0, -1, -1, 0);
    n_vec++; if (r_cycles != 26) begin n_err++; $display("FAIL maxit_latency: got %0d want 26", r_cycles); end
    n_vec++; if (r_n_commit != 3) begin n_err++; $display("FAIL maxit_commit: got %0d want 3", r_n_commit); end
    n_vec++; if (r_status !== 2'b01) begin n_err++; $display("FAIL maxit_status: got %b want 01", r_status); end
    n_vec++; if (r_iter != 3) begin n_err++; $display("FAIL maxit_iter: got %0d want 3", r_iter); end
    n_vec++; if (r_n_plu != 6) begin n_err++; $display("FAIL maxit_start_plu: got %0d want 6", r_n_plu); end
  endtask

  task automatic test_timeout();
    run(2, -1, 0, -1, -1, 0);
    n_vec++; if (r_cycles != 7) begin n_err++; $display("FAIL tmo_latency: got %0d want 7", r_cycles); end
    n_vec++; if (r_status !== 2'b10) begin n_err++; $display("FAIL tmo_status: got %b want 10", r_status); end
    n_vec++; if (r_iter != 0) begin n_err++; $display("FAIL tmo_iter: got %0d want 0", r_iter); end
    n_vec++; if (r_n_grp != 0) begin n_err++; $display("FAIL tmo_we_grp: got %0d want 0", r_n_grp); end
    run(2, 4, 1, -1, -1, 0);
    n_vec++; if (r_status !== 2'b00) begin n_err++; $display("FAIL tmo_edge_status: got %b want 00", r_status); end
    n_vec++; if (r_cycles != 28) begin n_err++; $display("FAIL tmo_edge_latency: got %0d want 28", r_cycles); end
    n_vec++; if (r_n_grp != 4) begin n_err++; $display("FAIL tmo_edge_we_grp: got %0d want 4", r_n_grp); end
  endtask

  task automatic test_abort();
    run(0, 1, 0, 2, 1, 0);
    n_vec++; if (r_abort_cyc != 23) begin n_err++; $display("FAIL abort_point: got %0d want 23", r_abort_cyc); end
    n_vec++; if (r_cycles != 24) begin n_err++; $display("FAIL abort_finish_cycle: got %0d want 24", r_cycles); end
    n_vec++; if (r_status !== 2'b11) begin n_err++; $display("FAIL abort_status: got %b want 11", r_status); end
    n_vec++; if (r_iter != 1) begin n_err++; $display("FAIL abort_iter: got %0d want 1", r_iter); end
    n_vec++; if (r_n_plu != 7 || r_plu_after_abort != 0) begin
      n_err++; $display("FAIL abort_start_plu: got %0d/%0d want 7/0", r_n_plu, r_plu_after_abort);
    end
    run(0, 1, 1, -1, -1, 0);
    n_vec++; if (r_c1 !== 6'b111111) begin n_err++; $display("FAIL restart_init_strobes: got %b want 111111", r_c1); end
    n_vec++; if (r_c2_status !== 2'b00 || r_c2_iter != 0) begin
      n_err++; $display("FAIL restart_cleared: got status=%b iter=%0d want 00/0", r_c2_status, r_c2_iter);
    end
    n_vec++; if (r_cycles != 16 || r_status !== 2'b00) begin
      n_err++; $display("FAIL restart_run: got %0d/%b want 16/00", r_cycles, r_status);
    end
  endtask

  task automatic test_reset_mid_run();
    int stores, guard, fin_seen, busy_seen;
    sel = 0; start = 1; stores = 0; guard = 0; plu_done = 0; valid = 0; abort = 0;
    while (stores < 6 && guard < 100) begin
      @(negedge clk);
      guard++;
      start = 0;
      plu_done = (!o.start_plu && o.busy && !o.we_grp && !o.we_a_reg && !o.finish);
      if (o.we_grp) stores++;
    end
    n_vec++; if (stores != 6) begin n_err++; $display("FAIL rst_reach_store: got %0d want 6", stores); end
    rst = 1; plu_done = 0;
    @(negedge clk);
    n_vec++; if (o !== '0) begin n_err++; $display("FAIL rst_in_store: got %h want 0", o); end
    rst = 0; fin_seen = 0; busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (o.finish) fin_seen++;
      if (o.busy) busy_seen++;
    end
    n_vec++; if (fin_seen != 0 || busy_seen != 0) begin
      n_err++; $display("FAIL rst_no_finish: got finish=%0d busy=%0d want 0/0", fin_seen, busy_seen);
    end
  endtask

  task automatic test_start_held();
    run(0, 1, 1, -1, -1, 1);
    n_vec++; if (r_cycles != 16) begin n_err++; $display("FAIL held_latency: got %0d want 16", r_cycles); end
    n_vec++; if (r_n_init != 1) begin n_err++; $display("FAIL held_init_count: got %0d want 1", r_n_init); end
    n_vec++; if (r_after_busy !== 1'b0) begin n_err++; $display("FAIL held_idle: got busy=%b want 0", r_after_busy); end
  endtask

  task automatic test_single_group();
    bit ok;
    run(3, 1, 1, -1, -1, 0);
    n_vec++; if (r_cycles != 7) begin n_err++; $display("FAIL g1_latency: got %0d want 7", r_cycles); end
    n_vec++; if (r_n_plu != 1) begin n_err++; $display("FAIL g1_start_plu: got %0d want 1", r_n_plu); end
    run(3, 1, 2, -1, -1, 0);
    ok = (q_grp.size() == 2);
    for (int i = 0; i < q_grp.size(); i++) if (q_grp[i] != 0) ok = 0;
    n_vec++; if (!ok) begin n_err++; $display("FAIL g1_grp_seq: got %p want 0,0", q_grp); end
    n_vec++; if (r_cycles != 12) begin n_err++; $display("FAIL g1_two_iter_latency: got %0d want 12", r_cycles); end
    n_vec++; if (r_iter != 2 || r_n_commit != 2) begin
      n_err++; $display("FAIL g1_two_iter_count: got %0d/%0d want 2/2", r_iter, r_n_commit);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_iter();
    test_timeout();
    test_abort();
    test_reset_mid_run();
    test_start_held();
    test_single_group();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no end of run want finish before 200000");
    $fatal(1, "time limit");
  end

endmodule
